// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and datapath width for the ALU arbiter slice.
// Pure declarations; no logic, no latency.
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Opcodes 110 and 111 are unassigned and flagged on the response.
    function automatic logic is_illegal(input logic [2:0] op);
        return op[2:1] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-port request/response channel between requesters and the ALU arbiter.
// Request and response are independent valid/ready handshakes, one bit per port.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int W = ALU_W
);
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req_a0;
    logic [W-1:0] req_b0;
    logic [W-1:0] req_a1;
    logic [W-1:0] req_b1;
    logic [2:0]   req_op0;
    logic [2:0]   req_op1;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_illegal;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_illegal
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_illegal
    );
endinterface

// File: rtl/alu.sv
// 16-bit combinational ALU; zero latency, no handshake.
// Results truncate to 16 bits; unassigned opcodes yield zero.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [2:0]       alu_op_code,
    output logic [ALU_W-1:0] result
);

    always_comb begin
        result = '0;
        case (alu_op_code)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_NAND: result = ~(a & b);
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin two-port sequencer around one shared ALU: accept, execute, respond.
// Result appears one edge after acceptance; response back-pressure stalls new grants.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
)(
    input  logic               clk,
    input  logic               rst,
    alu_arbiter_if.slave       bus,
    output logic               busy,
    output logic [15:0]        op_count
);

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               illegal_q, illegal_d;
    logic [15:0]        op_count_q, op_count_d;
    logic               win;
    logic [1:0]         req_ready;
    logic [ALU_W-1:0]   alu_res;

    alu u_alu (
        .a           (a_q),
        .b           (b_q),
        .alu_op_code (op_q),
        .result      (alu_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_valid_q  <= '0;
            result_q     <= '0;
            illegal_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp_valid_q  <= rsp_valid_d;
            result_q     <= result_d;
            illegal_q    <= illegal_d;
            op_count_q   <= op_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        rsp_valid_d  = rsp_valid_q;
        result_d     = result_q;
        illegal_d    = illegal_q;
        op_count_d   = op_count_q;
        req_ready    = 2'b00;
        // On a tie the port not served last wins; otherwise the lone valid port.
        win          = (bus.req_valid == 2'b11) ? ~last_grant_q : bus.req_valid[1];

        case (state_q)
            IDLE: begin
                if (bus.req_valid != 2'b00) begin
                    req_ready[win] = 1'b1;
                    grant_d        = win;
                    a_d            = win ? bus.req_a1  : bus.req_a0;
                    b_d            = win ? bus.req_b1  : bus.req_b0;
                    op_d           = win ? bus.req_op1 : bus.req_op0;
                    state_d        = EXEC;
                end
            end
            EXEC: begin
                result_d             = alu_res;
                illegal_d            = is_illegal(op_q);
                rsp_valid_d          = 2'b00;
                rsp_valid_d[grant_q] = 1'b1;
                state_d              = RESP;
            end
            RESP: begin
                if (bus.rsp_ready[grant_q]) begin
                    rsp_valid_d  = 2'b00;
                    last_grant_d = grant_q;
                    op_count_d   = op_count_q + 16'd1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready   = req_ready;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_result  = result_q;
    assign bus.rsp_illegal = illegal_q;
    assign busy            = (state_q != IDLE);
    assign op_count        = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter against a behavioural model.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] op_count;

    int          checks = 0;
    int          errors = 0;

    // Model state: which port was served last and how many responses completed.
    logic        mdl_last;
    logic [15:0] mdl_count;
    logic        g;

    alu_arbiter_if #(.W(16)) bus ();

    alu_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        longint ua, ub, r;
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            3'd0:    r = (ua + ub) % 65536;
            3'd1:    r = (ua - ub + 65536) % 65536;
            3'd2:    r = (ua * ub) % 65536;
            3'd3:    r = 65535 - (ua & ub);
            3'd4:    r = ua & ub;
            3'd5:    r = ua | ub;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    function automatic logic [1:0] onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic p);
        if (p) begin
            bus.req_a1  = 16'($urandom);
            bus.req_b1  = 16'($urandom);
            bus.req_op1 = 3'($urandom_range(0, 7));
        end else begin
            bus.req_a0  = 16'($urandom);
            bus.req_b0  = 16'($urandom);
            bus.req_op0 = 3'($urandom_range(0, 7));
        end
        bus.req_valid[p] = 1'b1;
    endtask

    // One full transaction from acceptance to response handshake, with bp stall cycles.
    task automatic run_txn(input string tag, input int bp, output logic gnt);
        int          w;
        logic [15:0] ea, eb, er;
        logic [2:0]  eop;
        w = 0;
        gnt = 1'b0;
        #1;
        while (bus.req_ready == 2'b00 && w < 20) begin
            @(posedge clk); #4;
            w++;
        end
        check({tag, " accept_seen"}, 32'(bus.req_ready != 2'b00), 32'd1);
        if (w >= 20) return;
        gnt = (bus.req_valid == 2'b11) ? ~mdl_last : bus.req_valid[1];
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'(onehot(gnt)));
        ea  = gnt ? bus.req_a1  : bus.req_a0;
        eb  = gnt ? bus.req_b1  : bus.req_b0;
        eop = gnt ? bus.req_op1 : bus.req_op0;
        er  = ref_alu(eop, ea, eb);

        @(posedge clk); #3;
        check({tag, " exec_busy"}, 32'(busy), 32'd1);
        check({tag, " exec_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " exec_req_ready"}, 32'(bus.req_ready), 32'd0);

        @(posedge clk); #3;
        bus.rsp_ready = onehot(~gnt);
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(onehot(gnt)));
        check({tag, " result"}, 32'(bus.rsp_result), 32'(er));
        check({tag, " illegal"}, 32'(bus.rsp_illegal), 32'(eop >= 3'd6));

        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #3;
            check({tag, " hold_valid"}, 32'(bus.rsp_valid), 32'(onehot(gnt)));
            check({tag, " hold_result"}, 32'(bus.rsp_result), 32'(er));
            check({tag, " hold_req_ready"}, 32'(bus.req_ready), 32'd0);
        end

        bus.rsp_ready = onehot(gnt);
        @(posedge clk);
        mdl_last  = gnt;
        mdl_count = mdl_count + 16'd1;
        #3;
        bus.rsp_ready = 2'b00;
        #1;
        check({tag, " done_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " done_busy"}, 32'(busy), 32'd0);
        check({tag, " op_count"}, 32'(op_count), 32'(mdl_count));
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_a0    = '0;
        bus.req_b0    = '0;
        bus.req_a1    = '0;
        bus.req_b1    = '0;
        bus.req_op0   = '0;
        bus.req_op1   = '0;
        bus.rsp_ready = 2'b00;
        mdl_last      = 1'b1;
        mdl_count     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset result", 32'(bus.rsp_result), 32'd0);
        check("reset illegal", 32'(bus.rsp_illegal), 32'd0);
        check("reset op_count", 32'(op_count), 32'd0);
        check("reset req_ready", 32'(bus.req_ready), 32'd0);

        // Single op with minimum latency: 3 + 4 on port 0
        @(posedge clk); #3;
        bus.req_a0    = 16'h0003;
        bus.req_b0    = 16'h0004;
        bus.req_op0   = 3'b000;
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b11;
        #1;
        check("single req_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #3;
        bus.req_valid = 2'b00;
        check("single exec_busy", 32'(busy), 32'd1);
        check("single exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #3;
        check("single rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("single result", 32'(bus.rsp_result), 32'h0007);
        check("single illegal", 32'(bus.rsp_illegal), 32'd0);
        @(posedge clk); #3;
        bus.rsp_ready = 2'b00;
        mdl_last  = 1'b0;
        mdl_count = 16'd1;
        check("single done_valid", 32'(bus.rsp_valid), 32'd0);
        check("single op_count", 32'(op_count), 32'd1);

        // Back-pressure on port 1 while port 0 waits with an illegal opcode
        bus.req_a1    = 16'hFFFF;
        bus.req_b1    = 16'h00FF;
        bus.req_op1   = 3'b011;
        bus.req_a0    = 16'($urandom);
        bus.req_b0    = 16'($urandom);
        bus.req_op0   = 3'b111;
        bus.req_valid = 2'b11;
        run_txn("bp", 5, g);
        check("bp grant", 32'(g), 32'd1);
        bus.req_valid[1] = 1'b0;

        // Illegal opcode still counts as a completion
        run_txn("illegal", 1, g);
        check("illegal grant", 32'(g), 32'd0);
        bus.req_valid = 2'b00;

        // Reset during EXEC abandons the op
        bus.req_a0    = 16'h1234;
        bus.req_b0    = 16'h1111;
        bus.req_op0   = 3'b000;
        bus.req_valid = 2'b01;
        #1;
        check("rstmid req_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #3;
        bus.req_valid = 2'b00;
        rst = 1'b1;
        @(posedge clk); #3;
        rst = 1'b0;
        mdl_last  = 1'b1;
        mdl_count = '0;
        #1;
        check("rstmid busy", 32'(busy), 32'd0);
        check("rstmid rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rstmid op_count", 32'(op_count), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        check("rstmid no_response", 32'(bus.rsp_valid), 32'd0);

        // Continuous tie: grants must alternate starting with port 0
        bus.req_a0    = 16'h0000;
        bus.req_b0    = 16'h0001;
        bus.req_op0   = 3'b001;
        bus.req_a1    = 16'h0100;
        bus.req_b1    = 16'h0100;
        bus.req_op1   = 3'b010;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            run_txn("rr", i % 2, g);
            check("rr grant_order", 32'(g), 32'(i % 2));
        end
        bus.req_valid = 2'b00;

        // Randomized traffic honouring hold-until-accepted
        for (int i = 0; i < 25; i++) begin
            if (!bus.req_valid[0] && $urandom_range(0, 1) == 1) load(1'b0);
            if (!bus.req_valid[1] && $urandom_range(0, 1) == 1) load(1'b1);
            if (bus.req_valid == 2'b00) load(1'(i % 2));
            run_txn("rnd", int'($urandom_range(0, 3)), g);
            if ($urandom_range(0, 1) == 1) load(g);
            else bus.req_valid[g] = 1'b0;
        end
        bus.req_valid = 2'b00;
        @(posedge clk); #3;

        // Counter wrap: preload near the top, then complete two ops
        force dut.op_count_q = 16'hFFFE;
        #1;
        release dut.op_count_q;
        mdl_count = 16'hFFFE;
        #1;
        check("wrap preload", 32'(op_count), 32'hFFFE);
        load(1'b0);
        run_txn("wrap1", 0, g);
        run_txn("wrap2", 0, g);
        check("wrap zero", 32'(op_count), 32'h0000);
        bus.req_valid = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares the single 16-bit combinational ALU between two requesters: the CPU execute stage (port 0) and the address/auxiliary unit (port 1). It accepts one operation at a time over a valid/ready request channel, drives the ALU operands and opcode from internal registers, registers the result, and returns it on the winning port's valid/ready response channel. Arbitration is round-robin. The block sits between the requesters and the ALU instance, which it contains.

## Interface
- WIDTH, 16, operand/result width; the ALU is fixed at 16, so only 16 is supported.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit i belongs to port i.
- req_ready  out  2  per-port request accept; at most one bit is high.
- req_a0, req_b0, req_a1, req_b1  in  16 each  operands for port 0 and port 1.
- req_op0, req_op1  in  3 each  ALU opcodes for port 0 and port 1.
- rsp_valid  out  2  per-port response valid; at most one bit is high.
- rsp_ready  in  2  per-port response accept.
- rsp_result  out  16  result, shared by both ports and qualified by rsp_valid.
- rsp_illegal  out  1  the completed op used opcode 110 or 111.
- busy  out  1  high whenever the state is not IDLE.
- op_count  out  16  count of completed responses; wraps from 0xFFFF to 0.

## Operation
- State machine: IDLE → EXEC → RESP → IDLE.
- **IDLE, grant selection:**
  - With one valid port, that port is granted.
  - With both valid, the port not served last is granted.
  - req_ready[g] = (state==IDLE) & req_valid[g]. req_ready depends combinationally on req_valid, so requesters must not make valid depend on ready.
  - On req_valid[g] & req_ready[g], latch a, b, op and g, then go to EXEC.
- **EXEC:** the ALU is driven from the latched operands. At the end of the cycle, register the ALU output into rsp_result, set rsp_illegal = (op[2:1]==2'b11), set rsp_valid[g], and go to RESP.
- **RESP:** hold rsp_valid[g], rsp_result and rsp_illegal stable until rsp_ready[g]. On the handshake:
  - clear rsp_valid;
  - set last_grant = g;
  - increment op_count;
  - return to IDLE.
  - rsp_ready on the non-granted port is ignored.
- ALU semantics, results truncated to 16 bits:
  - 000: a+b, wraps.
  - 001: a−b, wraps.
  - 010: low 16 bits of a*b.
  - 011: ~(a&b).
  - 100: a&b.
  - 101: a|b.
  - 110/111: 0, with rsp_illegal set.
- Requests arriving during EXEC or RESP see req_ready=0 and must hold until accepted. No request is dropped.
- **Reset values:**
  - state IDLE; last_grant = 1, so port 0 wins the first tie.
  - rsp_valid = 0, rsp_result = 0, rsp_illegal = 0.
  - op_count = 0; busy = 0.
  - Latched operands and opcode = 0.
- **Reset mid-operation:** the in-flight op is abandoned, no response is produced, and op_count is unchanged from zero.

## Timing
- Request accepted at edge k → rsp_valid high after edge k+1, with the result valid in the same cycle.
- Minimum issue interval is 3 cycles (IDLE, EXEC, RESP with rsp_ready already high). The next acceptance occurs at edge k+3 at the earliest.
- Response back-pressure of n cycles adds n cycles. There is no internal queue.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1… Neither port waits for more than one other transaction.
- The ALU path is a single combinational cycle in EXEC. The multiply must close timing within one clk period.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams: OP_ADD=3'b000, OP_SUB, OP_MUL, OP_NAND, OP_AND, OP_OR;
  - the state encoding: IDLE, EXEC, RESP;
  - ALU_W=16.
- One sub-module instance: the existing alu (ports a, b, alu_op_code, result), fed from the latched operand registers.
- Grant logic and the FSM stay inline.

## Test plan
- **Single op:** after reset, port 0 sends a=0x0003, b=0x0004, op=000 with rsp_ready=1. Required: req_ready0 in the issue cycle, rsp_valid=01 two edges later, result 0x0007, op_count 1.
- **Tie and round-robin:** both ports valid continuously; port 0 op=001 a=0x0000 b=0x0001, port 1 op=010 a=0x0100 b=0x0100. Required: grants 0,1,0,1; results 0xFFFF (port 0) and 0x0000 (port 1, truncated multiply).
- **Back-pressure:** port 1 op=011 a=0xFFFF b=0x00FF, rsp_ready1 low for 5 cycles. Required: rsp_result holds 0xFF00 and rsp_valid holds 10 for all 5 cycles; req_ready stays 00 despite port 0 being valid.
- **Illegal op:** port 0 op=111. Required: result 0x0000 with rsp_illegal=1, and op_count still increments.
- **Reset mid-op:** assert rst in the EXEC cycle. Required: next cycle state IDLE, rsp_valid=00, busy=0, op_count=0; port 0 wins the next tie.
- **Counter wrap:** force 65536 completions. Required: op_count returns to 0x0000.
